// File: rtl/pmp_multi_checker.sv
// pmp_multi_checker
//   Registered, multi-channel PMP checker. Each channel presents a word access
//   (valid/ready) that is checked against the CSR PMP state sampled in the
//   accept cycle; the allow/deny result is returned one cycle later on a
//   per-channel response handshake with independent backpressure.
//   A sticky fault record (address/channel/type) and a saturating count of
//   faulting responses are kept for clint/debug.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   pmpcfg_i        cfg byte per entry: [7]L [4:3]A [2]X [1]W [0]R
//   pmpaddr_i       32-bit pmpaddr per entry (word address)
//   prv_i           privilege: 00 U, 01 S, 11 M (10 handled as U)
//   req_*           per-channel request: valid/ready, byte address, type
//                   (00 read, 01 write, 10 exec, 11 reserved)
//   resp_*          per-channel response: valid/ready, fault flag
//   fault_*_o       sticky fault record; fault_clr_i pulse clears it
//   fault_cnt_o     saturating count of faulting accepts
module pmp_multi_checker #(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned PMP_CNT = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PMP_CNT*8-1:0]       pmpcfg_i,
  input  logic [PMP_CNT*32-1:0]      pmpaddr_i,
  input  logic [1:0]                 prv_i,
  input  logic [CH_NUM-1:0]          req_valid_i,
  output logic [CH_NUM-1:0]          req_ready_o,
  input  logic [CH_NUM*ADDR_W-1:0]   req_addr_i,
  input  logic [CH_NUM*2-1:0]        req_type_i,
  output logic [CH_NUM-1:0]          resp_valid_o,
  input  logic [CH_NUM-1:0]          resp_ready_i,
  output logic [CH_NUM-1:0]          resp_fault_o,
  output logic                       fault_valid_o,
  output logic [ADDR_W-1:0]          fault_addr_o,
  output logic [1:0]                 fault_ch_o,
  output logic [1:0]                 fault_type_o,
  input  logic                       fault_clr_i,
  output logic [CNT_W-1:0]           fault_cnt_o
);

  // Word-address width; pmpaddr bits above this are ignored.
  localparam int unsigned WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } amode_e;

  typedef enum logic [1:0] {
    ACC_READ  = 2'b00,
    ACC_WRITE = 2'b01,
    ACC_EXEC  = 2'b10,
    ACC_RSVD  = 2'b11
  } acc_e;

  // Full PMP decision for one word access. The lowest-index matching entry
  // wins; TOR lower bound is the previous entry's address (0 for entry 0).
  function automatic logic access_fault(
    input logic [WA_W-1:0]        word,
    input logic [1:0]             acc,
    input logic [1:0]             prv,
    input logic [PMP_CNT*8-1:0]   cfg,
    input logic [PMP_CNT*32-1:0]  paddr
  );
    logic [WA_W-1:0] lo;
    logic [WA_W-1:0] hi;
    logic [WA_W-1:0] care;
    logic [7:0]      ecfg;
    logic [7:0]      sel_cfg;
    logic            found;
    logic            hit;
    logic            m_mode;
    logic            perm;
    m_mode  = (prv == 2'b11);
    found   = 1'b0;
    sel_cfg = '0;
    lo      = '0;
    for (int unsigned i = 0; i < PMP_CNT; i++) begin
      ecfg = cfg[i*8 +: 8];
      hi   = paddr[i*32 +: WA_W];
      // NAPOT: trailing ones plus the first zero are don't-care bits;
      // all-ones wraps to a zero care mask and so covers everything.
      care = ~(hi ^ (hi + WA_W'(1)));
      case (amode_e'(ecfg[4:3]))
        A_TOR:   hit = (word >= lo) && (word < hi);
        A_NA4:   hit = (word == hi);
        A_NAPOT: hit = ((word ^ hi) & care) == '0;
        default: hit = 1'b0;
      endcase
      if (hit && !found) begin
        found   = 1'b1;
        sel_cfg = ecfg;
      end
      lo = hi;
    end
    case (acc_e'(acc))
      ACC_READ:  perm = sel_cfg[0];
      ACC_WRITE: perm = sel_cfg[1];
      ACC_EXEC:  perm = sel_cfg[2];
      default:   perm = 1'b0;
    endcase
    if (acc_e'(acc) == ACC_RSVD)
      access_fault = 1'b1;
    else if (!found)
      access_fault = !m_mode;
    else if (m_mode && !sel_cfg[7])
      access_fault = 1'b0;
    else
      access_fault = !perm;
  endfunction

  logic [CH_NUM-1:0] accept;
  logic [CH_NUM-1:0] fault_now;
  logic [CH_NUM-1:0] fault_acc;

  always_comb begin
    req_ready_o = ~resp_valid_o | resp_ready_i;
    accept      = req_valid_i & req_ready_o;
    fault_now   = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      fault_now[c] = access_fault(req_addr_i[c*ADDR_W+2 +: WA_W],
                                  req_type_i[c*2 +: 2], prv_i,
                                  pmpcfg_i, pmpaddr_i);
    end
    fault_acc = accept & fault_now;
  end

  // Lowest-index faulting channel is the capture candidate.
  logic              cap_found;
  logic [1:0]        cap_ch;
  logic [ADDR_W-1:0] cap_addr;
  logic [1:0]        cap_type;
  logic [2:0]        n_fault;
  logic [CNT_W+2:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_next;

  always_comb begin
    cap_found = 1'b0;
    cap_ch    = '0;
    cap_addr  = '0;
    cap_type  = '0;
    n_fault   = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (fault_acc[c]) begin
        n_fault = n_fault + 3'd1;
        if (!cap_found) begin
          cap_found = 1'b1;
          cap_ch    = 2'(c);
          cap_addr  = req_addr_i[c*ADDR_W +: ADDR_W];
          cap_type  = req_type_i[c*2 +: 2];
        end
      end
    end
    cnt_sum  = {3'b000, fault_cnt_o} + (CNT_W+3)'(n_fault);
    cnt_next = (cnt_sum[CNT_W+2:CNT_W] != '0) ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_o  <= '0;
      resp_fault_o  <= '0;
      fault_valid_o <= 1'b0;
      fault_addr_o  <= '0;
      fault_ch_o    <= '0;
      fault_type_o  <= '0;
      fault_cnt_o   <= '0;
    end else begin
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        if (accept[c]) begin
          resp_valid_o[c] <= 1'b1;
          resp_fault_o[c] <= fault_now[c];
        end else if (resp_ready_i[c]) begin
          resp_valid_o[c] <= 1'b0;
          resp_fault_o[c] <= 1'b0;
        end
      end
      // A clear in the same cycle as a new fault re-arms the record
      // and captures the new fault instead of dropping it.
      if (cap_found && (!fault_valid_o || fault_clr_i)) begin
        fault_valid_o <= 1'b1;
        fault_addr_o  <= cap_addr;
        fault_ch_o    <= cap_ch;
        fault_type_o  <= cap_type;
      end else if (fault_clr_i) begin
        fault_valid_o <= 1'b0;
      end
      fault_cnt_o <= cnt_next;
    end
  end

endmodule

// File: tb/tb_pmp_multi_checker.sv
module tb_pmp_multi_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] pmpcfg;
  logic [511:0] pmpaddr;
  logic [1:0]   prv;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [63:0]  req_addr;
  logic [3:0]   req_type;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [1:0]   resp_fault;
  logic         fault_valid;
  logic [31:0]  fault_addr;
  logic [1:0]   fault_ch;
  logic [1:0]   fault_type;
  logic         fault_clr;
  logic [15:0]  fault_cnt;

  logic [1:0]   s_req_ready;
  logic [1:0]   s_resp_valid;
  logic [1:0]   s_resp_fault;
  logic         s_fault_valid;
  logic [31:0]  s_fault_addr;
  logic [1:0]   s_fault_ch;
  logic [1:0]   s_fault_type;
  logic [1:0]   s_fault_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmp_multi_checker #(.CH_NUM(2), .PMP_CNT(16), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pmpcfg_i(pmpcfg), .pmpaddr_i(pmpaddr), .prv_i(prv),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_type_i(req_type), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_fault_o(resp_fault), .fault_valid_o(fault_valid), .fault_addr_o(fault_addr),
    .fault_ch_o(fault_ch), .fault_type_o(fault_type), .fault_clr_i(fault_clr),
    .fault_cnt_o(fault_cnt)
  );

  pmp_multi_checker #(.CH_NUM(2), .PMP_CNT(16), .ADDR_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pmpcfg_i(pmpcfg), .pmpaddr_i(pmpaddr), .prv_i(prv),
    .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_addr_i(req_addr),
    .req_type_i(req_type), .resp_valid_o(s_resp_valid), .resp_ready_i(resp_ready),
    .resp_fault_o(s_resp_fault), .fault_valid_o(s_fault_valid), .fault_addr_o(s_fault_addr),
    .fault_ch_o(s_fault_ch), .fault_type_o(s_fault_type), .fault_clr_i(fault_clr),
    .fault_cnt_o(s_fault_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic [31:0] a, input logic [1:0] t);
    req_valid[c]         = 1'b1;
    req_addr[c*32 +: 32] = a;
    req_type[c*2 +: 2]   = t;
  endtask

  task automatic issue(input int c, input logic [31:0] a, input logic [1:0] t);
    put(c, a, t);
    step();
    req_valid = '0;
  endtask

  task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] a);
    pmpcfg[i*8 +: 8]    = c;
    pmpaddr[i*32 +: 32] = a;
  endtask

  task automatic test_reset();
    rst = 1'b0; pmpcfg = '1; pmpaddr = '1; prv = 2'b00;
    req_valid = 2'b11; req_addr = 64'h1234_5678_9ABC_DEF0; req_type = 4'b1111;
    resp_ready = 2'b00; fault_clr = 1'b0;
    repeat (3) step();
    checks++;
    if (resp_valid !== 2'b00 || resp_fault !== 2'b00) begin
      errors++; $display("FAIL reset_resp got v=%b f=%b exp 00 00", resp_valid, resp_fault);
    end
    checks++;
    if (fault_valid !== 1'b0 || fault_addr !== 32'h0 || fault_ch !== 2'b00 || fault_type !== 2'b00) begin
      errors++; $display("FAIL reset_record got v=%b a=%h c=%b t=%b exp all 0", fault_valid, fault_addr, fault_ch, fault_type);
    end
    checks++;
    if (fault_cnt !== 16'd0 || s_fault_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", fault_cnt, s_fault_cnt);
    end
    req_valid = '0; resp_ready = 2'b11; pmpcfg = '0; pmpaddr = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b exp 11", req_ready);
    end
  endtask

  task automatic test_napot();
    pmpcfg = '0; pmpaddr = '0; prv = 2'b00;
    set_entry(0, 8'h19, 32'h0000_01FF);
    issue(0, 32'h800, 2'b01);
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_fault[0] !== 1'b1) begin
      errors++; $display("FAIL napot_write got v=%b f=%b exp 1 1", resp_valid[0], resp_fault[0]);
    end
    checks++;
    if (fault_valid !== 1'b1 || fault_addr !== 32'h800 || fault_type !== 2'b01 || fault_ch !== 2'b00) begin
      errors++; $display("FAIL napot_record got v=%b a=%h t=%b c=%b exp 1 800 01 00", fault_valid, fault_addr, fault_type, fault_ch);
    end
    issue(0, 32'h800, 2'b00);
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_fault[0] !== 1'b0) begin
      errors++; $display("FAIL napot_read_in got v=%b f=%b exp 1 0", resp_valid[0], resp_fault[0]);
    end
    issue(0, 32'h1000, 2'b00);
    checks++;
    if (resp_fault[0] !== 1'b1) begin
      errors++; $display("FAIL napot_read_out got %b exp 1", resp_fault[0]);
    end
    checks++;
    if (fault_addr !== 32'h800 || fault_cnt !== 16'd2 || s_fault_cnt !== 2'd2) begin
      errors++; $display("FAIL napot_sticky got a=%h cnt=%0d scnt=%0d exp 800 2 2", fault_addr, fault_cnt, s_fault_cnt);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++;
    if (fault_valid !== 1'b0) begin
      errors++; $display("FAIL napot_clear got %b exp 0", fault_valid);
    end
  endtask

  task automatic test_tor_lock();
    pmpcfg = '0; pmpaddr = '0; prv = 2'b11;
    set_entry(0, 8'h8D, 32'h400);
    issue(0, 32'h100, 2'b01);
    checks++;
    if (resp_fault[0] !== 1'b1 || fault_valid !== 1'b1 || fault_addr !== 32'h100) begin
      errors++; $display("FAIL tor_locked_write got f=%b v=%b a=%h exp 1 1 100", resp_fault[0], fault_valid, fault_addr);
    end
    issue(0, 32'h100, 2'b00);
    checks++;
    if (resp_fault[0] !== 1'b0) begin
      errors++; $display("FAIL tor_locked_read got %b exp 0", resp_fault[0]);
    end
    issue(0, 32'hFFC, 2'b01);
    checks++;
    if (resp_fault[0] !== 1'b1) begin
      errors++; $display("FAIL tor_top_word got %b exp 1", resp_fault[0]);
    end
    issue(0, 32'h1000, 2'b01);
    checks++;
    if (resp_fault[0] !== 1'b0) begin
      errors++; $display("FAIL tor_upper_bound got %b exp 0", resp_fault[0]);
    end
    issue(0, 32'h2000, 2'b01);
    checks++;
    if (resp_fault[0] !== 1'b0) begin
      errors++; $display("FAIL tor_m_nomatch got %b exp 0", resp_fault[0]);
    end
    issue(1, 32'h2000, 2'b11);
    checks++;
    if (resp_valid[1] !== 1'b1 || resp_fault[1] !== 1'b1) begin
      errors++; $display("FAIL tor_reserved got v=%b f=%b exp 1 1", resp_valid[1], resp_fault[1]);
    end
    set_entry(0, 8'h0D, 32'h400);
    issue(0, 32'h100, 2'b01);
    checks++;
    if (resp_fault[0] !== 1'b0 || fault_cnt !== 16'd5 || fault_addr !== 32'h100) begin
      errors++; $display("FAIL tor_unlocked got f=%b cnt=%0d a=%h exp 0 5 100", resp_fault[0], fault_cnt, fault_addr);
    end
  endtask

  task automatic test_priority();
    pmpcfg = '0; pmpaddr = '0; prv = 2'b00;
    set_entry(0, 8'h10, 32'h40);
    set_entry(1, 8'h1F, 32'hFFFF_FFFF);
    issue(1, 32'h100, 2'b00);
    checks++;
    if (resp_fault[1] !== 1'b1) begin
      errors++; $display("FAIL prio_na4 got %b exp 1", resp_fault[1]);
    end
    issue(1, 32'h104, 2'b00);
    checks++;
    if (resp_fault[1] !== 1'b0) begin
      errors++; $display("FAIL prio_napot got %b exp 0", resp_fault[1]);
    end
    issue(0, 32'hFFFF_FFFC, 2'b10);
    checks++;
    if (resp_fault[0] !== 1'b0 || fault_cnt !== 16'd6) begin
      errors++; $display("FAIL prio_allspace got f=%b cnt=%0d exp 0 6", resp_fault[0], fault_cnt);
    end
  endtask

  task automatic test_backpressure();
    pmpcfg = '0; pmpaddr = '0; prv = 2'b00;
    set_entry(0, 8'h1F, 32'hFFFF_FFFF);
    resp_ready = 2'b01;
    put(1, 32'h300, 2'b11);
    step();
    put(1, 32'h304, 2'b00);
    for (int k = 0; k < 3; k++) begin
      put(0, 32'h10 + 32'(k) * 4, 2'b00);
      prv = (k == 1) ? 2'b11 : 2'b00;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
        errors++; $display("FAIL bp_ready cyc %0d got %b exp 01", k, req_ready);
      end
      step();
      checks++;
      if (resp_valid !== 2'b11 || resp_fault !== 2'b10) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b f=%b exp 11 10", k, resp_valid, resp_fault);
      end
    end
    prv = 2'b00;
    req_valid = '0;
    resp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b11) begin
      errors++; $display("FAIL bp_release_ready got %b exp 11", req_ready);
    end
    step();
    checks++;
    if (resp_valid !== 2'b00 || fault_cnt !== 16'd7) begin
      errors++; $display("FAIL bp_drain got v=%b cnt=%0d exp 00 7", resp_valid, fault_cnt);
    end
  endtask

  task automatic test_multi_fault();
    pmpcfg = '0; pmpaddr = '0; prv = 2'b00;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++;
    if (fault_valid !== 1'b0) begin
      errors++; $display("FAIL multi_preclear got %b exp 0", fault_valid);
    end
    put(0, 32'hA0, 2'b00);
    put(1, 32'hB0, 2'b10);
    step();
    req_valid = '0;
    checks++;
    if (resp_fault !== 2'b11 || fault_ch !== 2'b00 || fault_addr !== 32'hA0 || fault_type !== 2'b00 || fault_cnt !== 16'd9) begin
      errors++; $display("FAIL multi_same_cycle got f=%b c=%b a=%h t=%b cnt=%0d exp 11 00 a0 00 9", resp_fault, fault_ch, fault_addr, fault_type, fault_cnt);
    end
    fault_clr = 1'b1;
    put(1, 32'hC0, 2'b01);
    step();
    req_valid = '0;
    fault_clr = 1'b0;
    checks++;
    if (fault_valid !== 1'b1 || fault_ch !== 2'b01 || fault_addr !== 32'hC0 || fault_type !== 2'b01 || fault_cnt !== 16'd10) begin
      errors++; $display("FAIL multi_clr_recapture got v=%b c=%b a=%h t=%b cnt=%0d exp 1 01 c0 01 10", fault_valid, fault_ch, fault_addr, fault_type, fault_cnt);
    end
    checks++;
    if (s_fault_cnt !== 2'd3) begin
      errors++; $display("FAIL cnt_saturate got %0d exp 3", s_fault_cnt);
    end
  endtask

  task automatic test_reset_mid();
    pmpcfg = '0; pmpaddr = '0; prv = 2'b00;
    resp_ready = 2'b00;
    issue(0, 32'h40, 2'b00);
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_fault[0] !== 1'b1) begin
      errors++; $display("FAIL mid_pending got v=%b f=%b exp 1 1", resp_valid[0], resp_fault[0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 2'b00 || fault_valid !== 1'b0 || fault_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset got v=%b fv=%b cnt=%0d exp 00 0 0", resp_valid, fault_valid, fault_cnt);
    end
    step();
    rst = 1'b1;
    resp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b11 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL mid_release got r=%b v=%b exp 11 00", req_ready, resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_napot();
    test_tor_lock();
    test_priority();
    test_backpressure();
    test_multi_fault();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
